// File: rtl/apu_frame_counter.sv
// APU frame sequencer: CPU-cycle step counter driving quarter/half-frame enables and the frame IRQ.
// Optional macro FRAME_IRQ_EN adds the frame interrupt flag; without it frame_irq=0 and irq_l=1.
module apu_frame_counter #(
    parameter int CNT_WIDTH = 16,
    parameter int STEP1     = 7457,
    parameter int STEP2     = 14913,
    parameter int STEP3     = 22371,
    parameter int STEP4     = 29829,
    parameter int STEP5     = 37281
) (
    input  logic       clk,
    input  logic       rst_l,
    input  logic       cpu_clk_en,
    input  logic       reg_wr,
    input  logic [7:0] reg_wr_data,
    input  logic       status_rd,
    output logic       quarter_clk_en,
    output logic       half_clk_en,
    output logic       frame_irq,
    output logic       irq_l
);

    typedef logic [CNT_WIDTH-1:0] cnt_t;

    localparam cnt_t S1 = cnt_t'(STEP1);
    localparam cnt_t S2 = cnt_t'(STEP2);
    localparam cnt_t S3 = cnt_t'(STEP3);
    localparam cnt_t S4 = cnt_t'(STEP4);
    localparam cnt_t S5 = cnt_t'(STEP5);

    cnt_t       count_q, count_d;
    logic       parity_q, parity_d;
    logic       mode_q, mode_d;
    logic       pend_q, pend_d;
    logic [2:0] delay_q, delay_d;

    logic       wr_en;
    logic       expire;
    logic       hit1, hit2, hit3, hit4, hit5;
    cnt_t       last_step;

    assign wr_en     = cpu_clk_en & reg_wr;
    // A write landing on the expiry cycle restarts the delay instead of expiring.
    assign expire    = cpu_clk_en & pend_q & (delay_q == 3'd1) & ~reg_wr;
    assign hit1      = (count_q == S1);
    assign hit2      = (count_q == S2);
    assign hit3      = (count_q == S3);
    assign hit4      = (count_q == S4);
    assign hit5      = (count_q == S5);
    assign last_step = mode_q ? S5 : S4;

    always_comb begin
        quarter_clk_en = 1'b0;
        half_clk_en    = 1'b0;
        if (expire) begin
            quarter_clk_en = mode_q;
            half_clk_en    = mode_q;
        end else if (cpu_clk_en) begin
            quarter_clk_en = mode_q ? (hit1 | hit2 | hit3 | hit5) : (hit1 | hit2 | hit3 | hit4);
            half_clk_en    = mode_q ? (hit2 | hit5) : (hit2 | hit4);
        end
    end

    always_comb begin
        count_d  = count_q;
        parity_d = parity_q;
        mode_d   = mode_q;
        pend_d   = pend_q;
        delay_d  = delay_q;
        if (cpu_clk_en) begin
            parity_d = ~parity_q;
            if (expire || count_q >= last_step) begin
                count_d = '0;
            end else begin
                count_d = count_q + cnt_t'(1);
            end
            if (pend_q) begin
                delay_d = delay_q - 3'd1;
                if (expire) begin
                    pend_d = 1'b0;
                end
            end
            if (wr_en) begin
                mode_d  = reg_wr_data[7];
                pend_d  = 1'b1;
                delay_d = parity_q ? 3'd4 : 3'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            count_q  <= '0;
            parity_q <= 1'b0;
            mode_q   <= 1'b0;
            pend_q   <= 1'b0;
            delay_q  <= '0;
        end else begin
            count_q  <= count_d;
            parity_q <= parity_d;
            mode_q   <= mode_d;
            pend_q   <= pend_d;
            delay_q  <= delay_d;
        end
    end

`ifdef FRAME_IRQ_EN
    localparam cnt_t S4M1 = cnt_t'(STEP4 - 1);

    logic inhibit_q, inhibit_d;
    logic irq_q, irq_d;
    logic irq_set;

    assign irq_set = cpu_clk_en & ~mode_q & ~inhibit_q & ((count_q == S4M1) | hit4);

    // Priority: inhibiting write clears, then a set beats a same-cycle status read.
    always_comb begin
        inhibit_d = inhibit_q;
        irq_d     = irq_q;
        if (wr_en) begin
            inhibit_d = reg_wr_data[6];
        end
        if (wr_en && reg_wr_data[6]) begin
            irq_d = 1'b0;
        end else if (irq_set) begin
            irq_d = 1'b1;
        end else if (cpu_clk_en && status_rd) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            inhibit_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            inhibit_q <= inhibit_d;
            irq_q     <= irq_d;
        end
    end

    assign frame_irq = irq_q;
`else
    logic unused_irq_inputs;
    assign unused_irq_inputs = status_rd ^ reg_wr_data[6];
    assign frame_irq = 1'b0;
`endif

    assign irq_l = ~frame_irq;

    logic unused_data_bits;
    assign unused_data_bits = ^reg_wr_data[5:0];

endmodule

// File: tb/tb_apu_frame_counter.sv
// Directed bench for apu_frame_counter: full-size instance for real step counts,
// small-step instance for table vectors and write/delay/reset corner sequences.
module tb_apu_frame_counter;

    localparam int D1 = 7457;
    localparam int D2 = 14913;
    localparam int D3 = 22371;
    localparam int D4 = 29829;

`ifdef FRAME_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic       d_rst_l, d_en, d_wr, d_rd;
    logic [7:0] d_d;
    logic       d_q, d_h, d_irq, d_irql;

    logic       s_rst_l, s_en, s_wr, s_rd;
    logic [7:0] s_d;
    logic       s_q, s_h, s_irq, s_irql;

    apu_frame_counter dut_d (
        .clk(clk), .rst_l(d_rst_l), .cpu_clk_en(d_en), .reg_wr(d_wr),
        .reg_wr_data(d_d), .status_rd(d_rd), .quarter_clk_en(d_q),
        .half_clk_en(d_h), .frame_irq(d_irq), .irq_l(d_irql)
    );

    apu_frame_counter #(
        .CNT_WIDTH(8), .STEP1(5), .STEP2(10), .STEP3(15), .STEP4(20), .STEP5(25)
    ) dut_s (
        .clk(clk), .rst_l(s_rst_l), .cpu_clk_en(s_en), .reg_wr(s_wr),
        .reg_wr_data(s_d), .status_rd(s_rd), .quarter_clk_en(s_q),
        .half_clk_en(s_h), .frame_irq(s_irq), .irq_l(s_irql)
    );

    typedef struct {
        int         idle;
        logic       en;
        logic       wr;
        logic [7:0] d;
        logic       rd;
        logic       eq;
        logic       eh;
        logic       ei;
    } vec_t;

    vec_t tbl[17];

    function automatic logic irq_x(input logic v);
        return v & IRQ_ON;
    endfunction

    task automatic check(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b want %0b at %0t", nm, act, exp, $time);
        end
    endtask

    // chk: 0 = no checks, 1 = pulses and irq, 2 = irq only
    task automatic s_cycle(input logic en, input logic wr, input logic [7:0] d, input logic rd,
                           input logic eq, input logic eh, input logic ei, input int chk,
                           input string nm);
        s_en = en; s_wr = wr; s_d = d; s_rd = rd;
        @(negedge clk);
        if (chk == 1) begin
            check({nm, "_quarter"}, s_q, eq);
            check({nm, "_half"}, s_h, eh);
        end
        if (chk >= 1) begin
            check({nm, "_irq"}, s_irq, irq_x(ei));
            check({nm, "_irq_l"}, s_irql, ~irq_x(ei));
        end
        @(posedge clk); #1;
        s_en = 1'b0; s_wr = 1'b0; s_d = 8'h00; s_rd = 1'b0;
    endtask

    task automatic s_idle(input int n);
        for (int i = 0; i < n; i++) s_cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0, "idle");
    endtask

    task automatic s_reset();
        s_rst_l = 1'b0;
        @(posedge clk); #1;
        s_rst_l = 1'b1;
    endtask

    initial begin
        d_rst_l = 1'b0; d_en = 1'b0; d_wr = 1'b0; d_d = 8'h00; d_rd = 1'b0;
        s_rst_l = 1'b0; s_en = 1'b0; s_wr = 1'b0; s_d = 8'h00; s_rd = 1'b0;

        //            idle en wr  d     rd  q  h  irq
        tbl[0]  = '{0,  1, 0, 8'h00, 0, 0, 0, 0};   // count 0
        tbl[1]  = '{4,  1, 0, 8'h00, 0, 1, 0, 0};   // count 5: quarter
        tbl[2]  = '{4,  0, 0, 8'h00, 0, 0, 0, 0};   // count 10 without cpu_clk_en
        tbl[3]  = '{0,  1, 0, 8'h00, 0, 1, 1, 0};   // count 10: quarter+half
        tbl[4]  = '{4,  1, 0, 8'h00, 0, 1, 0, 0};   // count 15
        tbl[5]  = '{3,  1, 0, 8'h00, 0, 0, 0, 0};   // count 19: irq sets at edge
        tbl[6]  = '{0,  1, 0, 8'h00, 1, 1, 1, 1};   // count 20: set beats read
        tbl[7]  = '{0,  1, 0, 8'h00, 1, 0, 0, 1};   // count 0: read clears
        tbl[8]  = '{0,  1, 0, 8'h00, 0, 0, 0, 0};   // count 1
        tbl[9]  = '{1,  1, 1, 8'h80, 0, 0, 0, 0};   // count 3, parity 0: 5-step write
        tbl[10] = '{0,  1, 0, 8'h00, 0, 0, 0, 0};   // count 4
        tbl[11] = '{0,  1, 0, 8'h00, 0, 1, 0, 0};   // count 5: ordinary step
        tbl[12] = '{0,  1, 0, 8'h00, 0, 1, 1, 0};   // expiry: immediate pair
        tbl[13] = '{5,  1, 0, 8'h00, 0, 1, 0, 0};   // count 5 after restart
        tbl[14] = '{14, 1, 0, 8'h00, 0, 0, 0, 0};   // count 20 silent in 5-step
        tbl[15] = '{4,  1, 0, 8'h00, 0, 1, 1, 0};   // count 25: quarter+half
        tbl[16] = '{0,  1, 0, 8'h00, 0, 0, 0, 0};   // count 0, no irq in 5-step

        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_d_quarter", d_q, 1'b0);
        check("rst_d_half", d_h, 1'b0);
        check("rst_d_irq", d_irq, 1'b0);
        check("rst_d_irq_l", d_irql, 1'b1);
        check("rst_s_quarter", s_q, 1'b0);
        check("rst_s_irq_l", s_irql, 1'b1);
        @(posedge clk); #1;
        d_rst_l = 1'b1;

        // Full-size 4-step run: pulses, irq set at STEP4-1, read at STEP4-1 loses, later read clears
        for (int k = 0; k <= D4 + 1 + D1 + 3; k++) begin
            logic eq, eh, ei;
            d_en = 1'b1;
            d_rd = (k == D4 - 1) || (k == D4 + 6);
            eq = (k == D1) || (k == D2) || (k == D3) || (k == D4) || (k == D4 + 1 + D1);
            eh = (k == D2) || (k == D4);
            ei = irq_x((k >= D4) && (k <= D4 + 6));
            @(negedge clk);
            if (d_q !== eq) check($sformatf("dflt_quarter k=%0d", k), d_q, eq);
            else total++;
            if (d_h !== eh) check($sformatf("dflt_half k=%0d", k), d_h, eh);
            else total++;
            if (d_irq !== ei) check($sformatf("dflt_irq k=%0d", k), d_irq, ei);
            else total++;
            if (d_irql !== ~ei) check($sformatf("dflt_irq_l k=%0d", k), d_irql, ~ei);
            else total++;
            @(posedge clk); #1;
        end
        d_en = 1'b0;
        d_rd = 1'b0;

        s_rst_l = 1'b1;
        for (int i = 0; i < 17; i++) begin
            s_idle(tbl[i].idle);
            s_cycle(tbl[i].en, tbl[i].wr, tbl[i].d, tbl[i].rd, tbl[i].eq, tbl[i].eh, tbl[i].ei, 1,
                    $sformatf("vec%0d", i));
        end

        // Inhibit write clears a raised flag; flag stays low for two periods
        s_reset();
        s_idle(21);
        s_cycle(1'b1, 1'b1, 8'h40, 1'b0, 1'b0, 1'b0, 1'b1, 1, "inh_wr");
        for (int i = 0; i < 45; i++)
            s_cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2, $sformatf("inh_hold%0d", i));

        // Parity-1 write: 4-cycle delay, expiry on a step count suppresses the step pulse
        s_reset();
        s_cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1, "b_t0");
        s_cycle(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1, "b_wr_p1");
        for (int i = 2; i <= 4; i++)
            s_cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1, $sformatf("b_t%0d", i));
        s_cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1, "b_exp_on_step");
        s_idle(4);
        s_cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1, "b_t10");
        s_cycle(1'b1, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0, 1, "b_t11_wr");
        s_idle(2);
        s_cycle(1'b1, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1, "b_t14_rewr");
        s_cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1, "b_t15_no_old_exp");
        s_cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1, "b_t16_step2");
        s_cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1, "b_t17_restart_exp");
        s_cycle(1'b1, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1, "b_t18_wr");
        s_idle(1);

        // Asynchronous reset in the middle of a pending delay
        s_en = 1'b1;
        #2;
        s_rst_l = 1'b0;
        #1;
        check("midrst_quarter", s_q, 1'b0);
        check("midrst_half", s_h, 1'b0);
        check("midrst_irq", s_irq, 1'b0);
        check("midrst_irq_l", s_irql, 1'b1);
        @(posedge clk); #1;
        s_en = 1'b0;
        s_rst_l = 1'b1;
        for (int u = 0; u <= 20; u++)
            s_cycle(1'b1, 1'b0, 8'h00, 1'b0,
                    (u == 5) || (u == 10) || (u == 15) || (u == 20),
                    (u == 10) || (u == 20), 1'b0, 1, $sformatf("post_rst%0d", u));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
